lift_req_queue: RTL and testbench

- Request buffer on the producer side of the lift controller handshake.
- Accepts hall-call requests (floor + direction) from the button encoder and stores them in arrival order, dropping duplicates and illegal codes.
- Presents the oldest request to the lift FSM as a 3-bit request code plus an empty flag.
- Retires that request each cycle the lift FSM signals it is idle/ready.

---
 rtl/lift_req_queue_if.sv | 18 +
 rtl/lift_req_queue.sv | 83 ++++++++
 tb/tb_lift_req_queue.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/lift_req_queue_if.sv
// lift_req_queue_if: button-encoder / lift-FSM handshake bundle for the request queue
interface lift_req_queue_if;
  logic       btn_valid;
  logic [2:0] btn_code;
  logic       lift_done;
  logic [2:0] req_code;
  logic       q_empty;
  logic [3:0] count;
  logic       drop;
  modport master (
    output btn_valid, btn_code, lift_done,
    input  req_code, q_empty, count, drop
  );
  modport slave (
    input  btn_valid, btn_code, lift_done,
    output req_code, q_empty, count, drop
  );
endinterface

// File: rtl/lift_req_queue.sv
// lift_req_queue: in-order, de-duplicating hall-call buffer feeding the lift FSM
module lift_req_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst_n,
  lift_req_queue_if.slave bus
);
  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] FULL = 4'(DEPTH);

  logic [CW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic [5:0]    pend_q, pend_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] head;
  logic          pop, push, legal, dup, full;

  // Legal codes 1,2,3,4,6,7 are packed onto pending bits 0..5
  function automatic logic [2:0] pidx(input logic [CW-1:0] c);
    return (c == 3'd1) ? 3'd0 :
           (c == 3'd2) ? 3'd1 :
           (c == 3'd3) ? 3'd2 :
           (c == 3'd4) ? 3'd3 :
           (c == 3'd6) ? 3'd4 : 3'd5;
  endfunction

  // Accept/retire decisions; a code being popped this cycle may be re-queued
  always_comb begin
    head  = mem_q[rd_ptr_q];
    pop   = bus.lift_done && (count_q != 4'd0);
    legal = (bus.btn_code != 3'd0) && (bus.btn_code != 3'd5);
    dup   = pend_q[pidx(bus.btn_code)] && !(pop && head == bus.btn_code);
    full  = (count_q == FULL) && !pop;
    push  = bus.btn_valid && legal && !dup && !full;
  end

  // Next state; pending set is applied after clear so re-queueing the head keeps its bit
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + 4'(push) - 4'(pop);
    drop_d   = bus.btn_valid && !push;
    pend_d   = pend_q;
    if (pop)
      pend_d[pidx(head)] = 1'b0;
    if (push)
      pend_d[pidx(bus.btn_code)] = 1'b1;
  end

  // Control state, cleared asynchronously so a reset discards everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; contents are only meaningful below count so no reset is needed
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= bus.btn_code;
  end

  // Outputs come from registered state only
  always_comb begin
    bus.req_code = (count_q != 4'd0) ? head : '0;
    bus.q_empty  = (count_q == 4'd0);
    bus.count    = count_q;
    bus.drop     = drop_q;
  end
endmodule

// File: tb/tb_lift_req_queue.sv
// tb_lift_req_queue: vector table, corner sequences and a randomized scoreboard run
module tb_lift_req_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total = 0;

  lift_req_queue_if bus();
  lift_req_queue #(.DEPTH(4), .CW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] c;
    logic       d;
    logic [2:0] er;
    logic       ee;
    logic [3:0] ec;
    logic       ed;
  } vec_t;

  vec_t vt[26];
  logic [2:0] mq[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic d);
    bus.btn_valid = v;
    bus.btn_code  = c;
    bus.lift_done = d;
  endtask

  task automatic check_all(input string tag, input logic [2:0] er, input logic ee,
                           input logic [3:0] ec, input logic ed);
    check({tag, " req_code"}, int'(bus.req_code), int'(er));
    check({tag, " q_empty"}, int'(bus.q_empty), int'(ee));
    check({tag, " count"}, int'(bus.count), int'(ec));
    check({tag, " drop"}, int'(bus.drop), int'(ed));
  endtask

  initial begin
    // v, c, d -> req, empty, count, drop
    vt[0]  = '{1, 3'd3, 0, 3'd3, 0, 4'd1, 0};
    vt[1]  = '{1, 3'd6, 0, 3'd3, 0, 4'd2, 0};
    vt[2]  = '{0, 3'd0, 1, 3'd6, 0, 4'd1, 0};
    vt[3]  = '{0, 3'd0, 1, 3'd0, 1, 4'd0, 0};
    vt[4]  = '{1, 3'd1, 0, 3'd1, 0, 4'd1, 0};
    vt[5]  = '{1, 3'd1, 0, 3'd1, 0, 4'd1, 1};
    vt[6]  = '{1, 3'd5, 0, 3'd1, 0, 4'd1, 1};
    vt[7]  = '{1, 3'd0, 0, 3'd1, 0, 4'd1, 1};
    vt[8]  = '{0, 3'd0, 1, 3'd0, 1, 4'd0, 0};
    vt[9]  = '{1, 3'd1, 0, 3'd1, 0, 4'd1, 0};
    vt[10] = '{1, 3'd2, 0, 3'd1, 0, 4'd2, 0};
    vt[11] = '{1, 3'd3, 0, 3'd1, 0, 4'd3, 0};
    vt[12] = '{1, 3'd4, 0, 3'd1, 0, 4'd4, 0};
    vt[13] = '{1, 3'd6, 0, 3'd1, 0, 4'd4, 1};
    vt[14] = '{1, 3'd6, 1, 3'd2, 0, 4'd4, 0};
    vt[15] = '{0, 3'd0, 1, 3'd3, 0, 4'd3, 0};
    vt[16] = '{0, 3'd0, 1, 3'd4, 0, 4'd2, 0};
    vt[17] = '{0, 3'd0, 1, 3'd6, 0, 4'd1, 0};
    vt[18] = '{0, 3'd0, 1, 3'd0, 1, 4'd0, 0};
    vt[19] = '{0, 3'd0, 1, 3'd0, 1, 4'd0, 0};
    vt[20] = '{1, 3'd7, 0, 3'd7, 0, 4'd1, 0};
    vt[21] = '{1, 3'd7, 1, 3'd7, 0, 4'd1, 0};
    vt[22] = '{1, 3'd7, 0, 3'd7, 0, 4'd1, 1};
    vt[23] = '{0, 3'd0, 1, 3'd0, 1, 4'd0, 0};
    vt[24] = '{1, 3'd4, 1, 3'd4, 0, 4'd1, 0};
    vt[25] = '{0, 3'd0, 1, 3'd0, 1, 4'd0, 0};

    // Reset held with a valid request present
    drive(1, 3'd2, 0);
    #1;
    check_all("rst_t0", 3'd0, 1, 4'd0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("rst_hold", 3'd0, 1, 4'd0, 0);
    end
    drive(0, 3'd0, 0);
    rst_n = 1'b1;
    step();
    check_all("rst_release", 3'd0, 1, 4'd0, 0);

    for (int i = 0; i < 26; i++) begin
      drive(vt[i].v, vt[i].c, vt[i].d);
      step();
      check_all($sformatf("vec%0d", i), vt[i].er, vt[i].ee, vt[i].ec, vt[i].ed);
    end

    // Mid-cycle async reset with 3 entries and an in-flight drop
    drive(1, 3'd1, 0); step();
    drive(1, 3'd2, 0); step();
    drive(1, 3'd3, 0); step();
    drive(1, 3'd0, 0); step();
    check_all("pre_mid_rst", 3'd1, 0, 4'd3, 1);
    drive(0, 3'd0, 0);
    #2 rst_n = 1'b0;
    #1;
    check_all("mid_rst", 3'd0, 1, 4'd0, 0);
    #2 rst_n = 1'b1;
    drive(1, 3'd2, 0);
    step();
    check_all("post_rst_push", 3'd2, 0, 4'd1, 0);
    drive(0, 3'd0, 1);
    step();
    check_all("post_rst_drain", 3'd0, 1, 4'd0, 0);

    // Randomized run against a queue scoreboard
    mq.delete();
    for (int n = 0; n < 400; n++) begin
      logic v, d, pop_m, dup_m, acc_m;
      logic [2:0] c;
      v = ($urandom_range(0, 9) < 6);
      d = ($urandom_range(0, 9) < 4);
      c = 3'($urandom_range(0, 7));
      drive(v, c, d);
      #1;
      pop_m = d && (mq.size() > 0);
      dup_m = 1'b0;
      foreach (mq[k])
        if (mq[k] == c && !(pop_m && k == 0)) dup_m = 1'b1;
      acc_m = v && c != 3'd0 && c != 3'd5 && !dup_m && (mq.size() < 4 || pop_m);
      if (acc_m) mq.push_back(c);
      if (pop_m) check("sb_head", int'(bus.req_code), int'(mq.pop_front()));
      step();
      check("sb_count", int'(bus.count), mq.size());
      check("sb_drop", int'(bus.drop), int'(v && !acc_m));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
